writeback_queue: RTL and testbench

- Writeback stage sitting directly upstream of the register bank.
- Collects destination-register results from the ALU and the load/memory path, buffers them in order in a small FIFO, and drains exactly one write per cycle into the bank's write port (wVal/wReg/sig).
- Provides a forwarding lookup so decode can read results still pending in the queue.

---
 rtl/writeback_queue.sv | 95 +++++++++
 tb/tb_writeback_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Writeback queue: buffers ALU and load results in order and drains one
// register-bank write per cycle, with youngest-first forwarding lookup.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_val,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_val,
  output logic        mem_ready,
  input  logic [4:0]  fwd_reg,
  output logic        fwd_hit,
  output logic [31:0] fwd_val,
  output logic [31:0] wVal,
  output logic [4:0]  wReg,
  output logic        sig
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    q_reg [DEPTH];
  logic [31:0]   q_val [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, alu_slot, idx;
  logic [CW-1:0] count, free;
  logic          mem_enq, alu_enq, deq;

  // Readiness never credits a same-cycle pop, so acceptance only depends on count.
  always_comb free = CW'(DEPTH) - count;
  assign mem_ready = free >= CW'(1);
  assign alu_ready = (free >= CW'(2)) || ((free >= CW'(1)) && !mem_valid);

  // Writes to r0 complete the handshake but are dropped.
  assign mem_enq  = mem_valid && mem_ready && (mem_reg != 5'd0);
  assign alu_enq  = alu_valid && alu_ready && (alu_reg != 5'd0);
  assign deq      = count != '0;
  assign alu_slot = wr_ptr + PW'(mem_enq);

  always_ff @(posedge clk) begin
    if (mem_enq) begin
      q_reg[wr_ptr] <= mem_reg;
      q_val[wr_ptr] <= mem_val;
    end
    if (alu_enq) begin
      q_reg[alu_slot] <= alu_reg;
      q_val[alu_slot] <= alu_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sig    <= 1'b0;
      wReg   <= '0;
      wVal   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(mem_enq) + PW'(alu_enq);
      count  <= count + CW'(mem_enq) + CW'(alu_enq) - CW'(deq);
      sig    <= deq;
      if (deq) begin
        wReg   <= q_reg[rd_ptr];
        wVal   <= q_val[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins; output stage is oldest.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    idx     = '0;
    if (sig && wReg == fwd_reg) begin
      fwd_hit = 1'b1;
      fwd_val = wVal;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (q_reg[idx] == fwd_reg)) begin
        fwd_hit = 1'b1;
        fwd_val = q_val[idx];
      end
    end
    if (fwd_reg == 5'd0) begin
      fwd_hit = 1'b0;
      fwd_val = '0;
    end
  end
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: latency, ordering, r0 drop,
// backpressure with scoreboard, forwarding priority and async reset.
module tb_writeback_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, alu_ready, mem_ready;
  logic [4:0]  alu_reg, mem_reg, fwd_reg, wReg;
  logic [31:0] alu_val, mem_val, fwd_val, wVal;
  logic        fwd_hit, sig;

  int total = 0;
  int bad   = 0;

  writeback_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_val(alu_val), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_val(mem_val), .mem_ready(mem_ready),
    .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_val(fwd_val),
    .wVal(wVal), .wReg(wReg), .sig(sig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alu_valid = 1'b0; mem_valid = 1'b0;
    alu_reg = '0; alu_val = '0; mem_reg = '0; mem_val = '0;
  endtask

  logic [36:0] exp_q[$];
  logic [36:0] e;
  int cnt, m, a, deq, enq;

  initial begin
    rst = 1'b1; fwd_reg = '0;
    idle();
    #12;
    chk("rst_sig", sig, 0);
    chk("rst_wreg", wReg, 0);
    chk("rst_wval", wVal, 0);
    chk("rst_mrdy", mem_ready, 1);
    chk("rst_ardy", alu_ready, 1);
    rst = 1'b0;
    tick();

    // single ALU write, two-edge latency
    alu_valid = 1; alu_reg = 5; alu_val = 32'h0000_1234; fwd_reg = 5;
    #1 chk("t1_ardy", alu_ready, 1);
    tick(); idle();
    chk("t1_sig0", sig, 0);
    chk("t1_fwdq", fwd_hit, 1);
    chk("t1_fwdqv", fwd_val, 32'h1234);
    tick();
    chk("t1_sig1", sig, 1);
    chk("t1_wreg", wReg, 5);
    chk("t1_wval", wVal, 32'h0000_1234);
    chk("t1_fwdo", fwd_val, 32'h1234);
    tick();
    chk("t1_sig2", sig, 0);
    chk("t1_fwdn", fwd_hit, 0);

    // mem and alu on same edge: mem is older
    mem_valid = 1; mem_reg = 3; mem_val = 32'hAAAA_0000;
    alu_valid = 1; alu_reg = 4; alu_val = 32'h0000_BBBB;
    #1 chk("t2_mrdy", mem_ready, 1);
    chk("t2_ardy", alu_ready, 1);
    tick(); idle();
    chk("t2_sig0", sig, 0);
    tick();
    chk("t2_sigA", sig, 1);
    chk("t2_wregA", wReg, 3);
    chk("t2_wvalA", wVal, 32'hAAAA_0000);
    tick();
    chk("t2_sigB", sig, 1);
    chk("t2_wregB", wReg, 4);
    chk("t2_wvalB", wVal, 32'h0000_BBBB);
    tick();
    chk("t2_sigC", sig, 0);

    // r0 write accepted but dropped
    alu_valid = 1; alu_reg = 0; alu_val = 32'hFFFF_FFFF; fwd_reg = 0;
    #1 chk("t3_ardy", alu_ready, 1);
    chk("t3_fwd0", fwd_hit, 0);
    tick(); idle();
    chk("t3_ardy2", alu_ready, 1);
    tick();
    chk("t3_sig", sig, 0);
    chk("t3_wreg", wReg, 4);
    tick();
    chk("t3_sig2", sig, 0);

    // both producers held valid: backpressure and ordering
    cnt = 0; m = 0; a = 0;
    for (int c = 0; c < 14; c++) begin
      mem_valid = 1; mem_reg = 5'(1 + m % 15); mem_val = 32'h1000_0000 + 32'(m);
      alu_valid = 1; alu_reg = 5'(16 + a % 15); alu_val = 32'h2000_0000 + 32'(a);
      #1;
      chk("t4_mrdy", mem_ready, 32'(cnt <= 3));
      chk("t4_ardy", alu_ready, 32'(cnt <= 2));
      enq = 0;
      if (cnt <= 3) begin exp_q.push_back({mem_reg, mem_val}); m++; enq++; end
      if (cnt <= 2) begin exp_q.push_back({alu_reg, alu_val}); a++; enq++; end
      deq = (cnt > 0) ? 1 : 0;
      cnt = cnt + enq - deq;
      tick();
      chk("t4_sig", sig, 32'(deq));
      if (deq == 1) begin
        e = exp_q.pop_front();
        chk("t4_wreg", wReg, 32'(e[36:32]));
        chk("t4_wval", wVal, e[31:0]);
      end
    end
    idle();
    for (int c = 0; c < 6; c++) begin
      deq = (cnt > 0) ? 1 : 0;
      cnt = cnt - deq;
      tick();
      chk("t4_dsig", sig, 32'(deq));
      if (deq == 1) begin
        e = exp_q.pop_front();
        chk("t4_dwreg", wReg, 32'(e[36:32]));
        chk("t4_dwval", wVal, e[31:0]);
      end
    end
    chk("t4_empty", exp_q.size(), 0);

    // forwarding: youngest write to r7 wins
    fwd_reg = 7;
    mem_valid = 1; mem_reg = 9; mem_val = 32'h99;
    alu_valid = 1; alu_reg = 7; alu_val = 32'd1;
    tick(); idle();
    chk("t5_hit1", fwd_hit, 1);
    chk("t5_val1", fwd_val, 1);
    alu_valid = 1; alu_reg = 7; alu_val = 32'd2;
    #1 chk("t5_ardy", alu_ready, 1);
    tick(); idle();
    chk("t5_wreg9", wReg, 9);
    chk("t5_hit2", fwd_hit, 1);
    chk("t5_val2", fwd_val, 2);
    tick();
    chk("t5_val3", fwd_val, 2);
    chk("t5_wval3", wVal, 1);
    tick();
    chk("t5_hit4", fwd_hit, 1);
    chk("t5_val4", fwd_val, 2);
    tick();
    chk("t5_hit5", fwd_hit, 0);
    chk("t5_val5", fwd_val, 0);

    // async reset with entries in flight
    mem_valid = 1; mem_reg = 11; mem_val = 32'hB1;
    alu_valid = 1; alu_reg = 12; alu_val = 32'hC2;
    tick(); idle();
    alu_valid = 1; alu_reg = 13; alu_val = 32'hD3;
    tick(); idle();
    chk("t6_sigpre", sig, 1);
    fwd_reg = 12;
    #3 rst = 1'b1;
    #1;
    chk("t6_sig", sig, 0);
    chk("t6_wreg", wReg, 0);
    chk("t6_wval", wVal, 0);
    chk("t6_fwd", fwd_hit, 0);
    #2 rst = 1'b0;
    #1;
    chk("t6_mrdy", mem_ready, 1);
    chk("t6_ardy", alu_ready, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t6_nostale", sig, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
